load_store_unit: RTL and testbench

- Memory-access initiator between the CPU datapath and the word-organised data memory.
- The data memory has combinational read, synchronous write, and byte address A with the word selected by A>>2.
- This block accepts one CPU load/store request at a time and drives the memory address, write data and write enable.
- It performs sub-word extraction with sign/zero extension, does read-modify-write for byte/halfword stores, and reports completion and misalignment through a done/err handshake.

---
 rtl/load_store_unit.sv | 138 +++++++++++++
 tb/tb_load_store_unit.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-request load/store initiator with sub-word extract and read-modify-write
module load_store_unit #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              is_store,
   input  logic [2:0]        funct3,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t            state, state_nx;
   logic              st_q;
   logic [2:0]        f3_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] merge_q;
   logic              err_q;

   logic              illegal, misaligned, bad;
   logic [DATA_W-1:0] load_ext;
   logic [DATA_W-1:0] merged;
   logic [7:0]        ld_byte;
   logic [15:0]       ld_half;

   // Decode checks use the live request inputs because they are evaluated in IDLE.
   always_comb begin
      illegal    = 1'b0;
      misaligned = 1'b0;
      case (funct3)
         3'b000, 3'b001, 3'b010: illegal = 1'b0;
         3'b100, 3'b101:         illegal = is_store;
         default:                illegal = 1'b1;
      endcase
      if (funct3[1:0] == 2'b01 && addr[0])
         misaligned = 1'b1;
      if (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00)
         misaligned = 1'b1;
      bad = illegal | misaligned;
   end

   always_comb begin
      ld_byte  = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
      ld_half  = mem_rdata[{addr_q[1], 4'b0000} +: 16];
      load_ext = mem_rdata;
      case (f3_q)
         3'b000:  load_ext = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
         3'b100:  load_ext = {{(DATA_W-8){1'b0}}, ld_byte};
         3'b001:  load_ext = {{(DATA_W-16){ld_half[15]}}, ld_half};
         3'b101:  load_ext = {{(DATA_W-16){1'b0}}, ld_half};
         default: load_ext = mem_rdata;
      endcase
   end

   // Little-endian lane replacement into the word captured during READ.
   always_comb begin
      merged = merge_q;
      if (f3_q[1:0] == 2'b00)
         merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      else
         merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (req) begin
               if (bad)
                  state_nx = DONE;
               else if (is_store && funct3 == 3'b010)
                  state_nx = WRITE;
               else
                  state_nx = READ;
            end
         end
         READ:    state_nx = st_q ? WRITE : DONE;
         WRITE:   state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         st_q    <= 1'b0;
         f3_q    <= 3'b000;
         addr_q  <= '0;
         wdata_q <= '0;
         merge_q <= '0;
         err_q   <= 1'b0;
         rdata   <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && req) begin
            st_q    <= is_store;
            f3_q    <= funct3;
            addr_q  <= addr;
            wdata_q <= wdata;
            err_q   <= bad;
         end
         if (state == READ) begin
            if (st_q)
               merge_q <= mem_rdata;
            else
               rdata <= load_ext;
         end
      end
   end

   // Write enable is gated by reset so an abort landing in WRITE never reaches memory.
   assign busy     = (state != IDLE);
   assign done     = (state == DONE);
   assign err      = (state == DONE) && err_q;
   assign mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
   assign mem_we   = (state == WRITE) && rst;

   always_comb begin
      mem_wdata = '0;
      if (state == WRITE)
         mem_wdata = (f3_q[1:0] == 2'b10) ? wdata_q : merged;
   end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - table-driven bench for load_store_unit with a word memory model
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic        is_store;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        busy, done, err, mem_we;
   logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

   logic [31:0] mem [0:63];

   int errors = 0;
   int checks = 0;

   load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst), .req(req), .is_store(is_store), .funct3(funct3),
      .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
      .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_we(mem_we), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr[7:2]];
   always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;

   typedef struct {
      logic        st;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] wd;
      int          lat;
      logic        e;
      logic [31:0] rd;
      int          we_cnt;
      logic [31:0] we_addr;
      logic [31:0] we_data;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   int          op_lat, op_we_cnt;
   logic        op_err;
   logic [31:0] op_we_addr, op_we_data;

   // Issues one request and returns at the negedge of its done cycle.
   task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
      @(negedge clk);
      req = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
      op_lat = -1; op_we_cnt = 0; op_err = 1'b0; op_we_addr = '0; op_we_data = '0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         req = 1'b0;
         if (mem_we) begin
            op_we_cnt++;
            op_we_addr = mem_addr;
            op_we_data = mem_wdata;
         end
         if (done) begin
            op_lat = c;
            op_err = err;
            break;
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      mem[16] = 32'h8899AABB;
      rst = 1'b0; req = 1'b0; is_store = 1'b0; funct3 = 3'b000; addr = '0; wdata = '0;

      vecs.push_back('{1'b0, 3'b000, 32'h41, 32'h0,        2, 1'b0, 32'hFFFFFFAA, 0, 32'h0,  32'h0});
      vecs.push_back('{1'b0, 3'b100, 32'h43, 32'h0,        2, 1'b0, 32'h00000088, 0, 32'h0,  32'h0});
      vecs.push_back('{1'b0, 3'b001, 32'h42, 32'h0,        2, 1'b0, 32'hFFFF8899, 0, 32'h0,  32'h0});
      vecs.push_back('{1'b0, 3'b101, 32'h40, 32'h0,        2, 1'b0, 32'h0000AABB, 0, 32'h0,  32'h0});
      vecs.push_back('{1'b0, 3'b010, 32'h40, 32'h0,        2, 1'b0, 32'h8899AABB, 0, 32'h0,  32'h0});
      vecs.push_back('{1'b1, 3'b000, 32'h42, 32'h12345677, 3, 1'b0, 32'h8899AABB, 1, 32'h40, 32'h8877AABB});
      vecs.push_back('{1'b0, 3'b010, 32'h40, 32'h0,        2, 1'b0, 32'h8877AABB, 0, 32'h0,  32'h0});
      vecs.push_back('{1'b1, 3'b010, 32'h44, 32'hDEADBEEF, 2, 1'b0, 32'h8877AABB, 1, 32'h44, 32'hDEADBEEF});
      vecs.push_back('{1'b0, 3'b010, 32'h44, 32'h0,        2, 1'b0, 32'hDEADBEEF, 0, 32'h0,  32'h0});
      vecs.push_back('{1'b0, 3'b010, 32'h42, 32'h0,        1, 1'b1, 32'hDEADBEEF, 0, 32'h0,  32'h0});
      vecs.push_back('{1'b1, 3'b001, 32'h41, 32'hFFFF,     1, 1'b1, 32'hDEADBEEF, 0, 32'h0,  32'h0});
      vecs.push_back('{1'b1, 3'b100, 32'h40, 32'hFF,       1, 1'b1, 32'hDEADBEEF, 0, 32'h0,  32'h0});
      vecs.push_back('{1'b0, 3'b011, 32'h40, 32'h0,        1, 1'b1, 32'hDEADBEEF, 0, 32'h0,  32'h0});
      vecs.push_back('{1'b1, 3'b001, 32'h46, 32'h1111CAFE, 3, 1'b0, 32'hDEADBEEF, 1, 32'h44, 32'hCAFEBEEF});
      vecs.push_back('{1'b0, 3'b001, 32'h46, 32'h0,        2, 1'b0, 32'hFFFFCAFE, 0, 32'h0,  32'h0});
      vecs.push_back('{1'b0, 3'b000, 32'h40, 32'h0,        2, 1'b0, 32'hFFFFFFBB, 0, 32'h0,  32'h0});
      vecs.push_back('{1'b0, 3'b010, 32'h40, 32'h0,        2, 1'b0, 32'h8877AABB, 0, 32'h0,  32'h0});

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset busy",      {31'b0, busy},   32'h0);
      check("reset done",      {31'b0, done},   32'h0);
      check("reset err",       {31'b0, err},    32'h0);
      check("reset rdata",     rdata,           32'h0);
      check("reset mem_we",    {31'b0, mem_we}, 32'h0);
      check("reset mem_addr",  mem_addr,        32'h0);
      check("reset mem_wdata", mem_wdata,       32'h0);
      rst = 1'b1;

      foreach (vecs[i]) begin
         do_op(vecs[i].st, vecs[i].f3, vecs[i].a, vecs[i].wd);
         check($sformatf("v%0d latency", i), op_lat, vecs[i].lat);
         check($sformatf("v%0d err", i), {31'b0, op_err}, {31'b0, vecs[i].e});
         check($sformatf("v%0d rdata", i), rdata, vecs[i].rd);
         check($sformatf("v%0d we_cnt", i), op_we_cnt, vecs[i].we_cnt);
         if (vecs[i].we_cnt == 1) begin
            check($sformatf("v%0d we_addr", i), op_we_addr, vecs[i].we_addr);
            check($sformatf("v%0d we_data", i), op_we_data, vecs[i].we_data);
         end
      end

      // Reset lands during the READ of a byte store: no write, back to IDLE.
      @(negedge clk);
      req = 1'b1; is_store = 1'b1; funct3 = 3'b000; addr = 32'h40; wdata = 32'h55;
      @(negedge clk);
      check("abort busy in read", {31'b0, busy}, 32'h1);
      rst = 1'b0;
      @(negedge clk);
      check("abort busy",   {31'b0, busy},   32'h0);
      check("abort mem_we", {31'b0, mem_we}, 32'h0);
      check("abort done",   {31'b0, done},   32'h0);
      req = 1'b0; rst = 1'b1;
      @(negedge clk);
      check("abort mem_we after", {31'b0, mem_we}, 32'h0);
      check("abort word kept", mem[16], 32'h8877AABB);

      // req held high: a second load is taken only after the DONE cycle.
      begin
         int first_done, second_done, we_seen;
         first_done = -1; second_done = -1; we_seen = 0;
         @(negedge clk);
         req = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h44; wdata = 32'h0;
         for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (mem_we) we_seen++;
            if (done && first_done < 0) first_done = c;
            else if (done && second_done < 0) second_done = c;
         end
         req = 1'b0;
         check("held req first done",  first_done,  2);
         check("held req second done", second_done, 5);
         check("held req no write",    we_seen,     0);
         check("held req rdata",       rdata,       32'hCAFEBEEF);
      end

      repeat (2) @(negedge clk);
      check("idle busy", {31'b0, busy}, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
